// File: rtl/gun_pkg.sv
// gun_pkg: shared constants, lock states and the position clamp for the light-gun responder
package gun_pkg;
  localparam logic [5:0] GUN_MAX = 6'd62;
  localparam logic SEL_H = 1'b0;
  localparam logic SEL_V = 1'b1;
  localparam int XH_ARM = 3;
  typedef enum logic {IDLE, LOCKED} gun_lock_t;
  function automatic logic [5:0] gun_clamp(input logic [5:0] p);
    return (p > GUN_MAX) ? GUN_MAX : p;
  endfunction
endpackage

// File: rtl/gun_crosshair.sv
// gun_crosshair: registered crosshair pixel centred on the sampled gun position
module gun_crosshair import gun_pkg::*; #(
  parameter int H_OFFSET = 48,
  parameter int V_OFFSET = 16
) (
  input  logic       clock_12,
  input  logic       reset_n,
  input  logic [5:0] sh_h,
  input  logic [5:0] sh_v,
  input  logic [8:0] hcnt,
  input  logic [8:0] vcnt,
  output logic       xhair
);
  logic [8:0] x, y;
  logic hit;
  function automatic logic near(input logic [8:0] a, input logic [8:0] b);
    return ({1'b0, a} + 10'(XH_ARM) >= {1'b0, b}) && ({1'b0, a} <= {1'b0, b} + 10'(XH_ARM));
  endfunction
  assign x = 9'(H_OFFSET) + {1'b0, sh_h, 2'b00};
  assign y = 9'(V_OFFSET) + {1'b0, sh_v, 2'b00};
  assign hit = ((vcnt == y) && near(hcnt, x)) || ((hcnt == x) && near(vcnt, y));
  always_ff @(posedge clock_12 or negedge reset_n)
    if (!reset_n) xhair <= 1'b0;
    else xhair <= hit;
endmodule

// File: rtl/gun_port_responder.sv
// gun_port_responder: coherent gun position snapshot with H-then-V CPU lock protocol.
// Define GUN_CROSSHAIR_EN to build the crosshair overlay; otherwise xhair is tied low.
module gun_port_responder import gun_pkg::*; #(
  parameter int LOCK_TIMEOUT = 4096,
  parameter int H_OFFSET = 48,
  parameter int V_OFFSET = 16
) (
  input  logic       clock_12,
  input  logic       reset_n,
  input  logic [5:0] gun_h,
  input  logic [5:0] gun_v,
  input  logic       cnt_4ms,
  input  logic       cpu_rd,
  input  logic       cpu_sel,
  output logic [7:0] cpu_dout,
  output logic       cpu_dout_valid,
  output logic       sample_new,
  input  logic [8:0] hcnt,
  input  logic [8:0] vcnt,
  output logic       xhair
);
  localparam int CW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  gun_lock_t state, state_d;
  logic tick_q, tick, rd_h, rd_v, pd_valid, pd_valid_d, new_d;
  logic [5:0] sh_h, sh_v, pd_h, pd_v, in_h, in_v;
  logic [5:0] sh_h_d, sh_v_d, pd_h_d, pd_v_d;
  logic [CW-1:0] cnt, cnt_d;
  assign tick = cnt_4ms & ~tick_q;
  assign rd_h = cpu_rd & (cpu_sel == SEL_H);
  assign rd_v = cpu_rd & (cpu_sel == SEL_V);
  assign in_h = gun_clamp(gun_h);
  assign in_v = gun_clamp(gun_v);
  always_comb begin
    state_d = state;
    {sh_h_d, sh_v_d} = {sh_h, sh_v};
    {pd_h_d, pd_v_d} = {pd_h, pd_v};
    pd_valid_d = pd_valid;
    new_d = sample_new;
    cnt_d = cnt;
    if (state == IDLE) begin
      if (pd_valid) {sh_h_d, sh_v_d, pd_valid_d, new_d} = {pd_h, pd_v, 1'b0, 1'b1};
      if (rd_h) begin
        state_d = LOCKED;
        cnt_d = CW'(LOCK_TIMEOUT - 1);
        new_d = pd_valid;
        if (tick) {pd_h_d, pd_v_d, pd_valid_d} = {in_h, in_v, 1'b1};
      end else if (tick) {sh_h_d, sh_v_d, new_d} = {in_h, in_v, 1'b1};
    end else begin
      if (tick) {pd_h_d, pd_v_d, pd_valid_d} = {in_h, in_v, 1'b1};
      if (rd_h) begin
        cnt_d = CW'(LOCK_TIMEOUT - 1);
        new_d = 1'b0;
      end else if (rd_v || cnt == '0) begin
        state_d = IDLE;
        // a tick on the release edge is promoted on the following IDLE cycle instead
        if (pd_valid && !tick) {sh_h_d, sh_v_d, pd_valid_d, new_d} = {pd_h, pd_v, 1'b0, 1'b1};
      end else cnt_d = cnt - 1'b1;
    end
  end
  always_ff @(posedge clock_12 or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      tick_q <= 1'b0;
      {sh_h, sh_v, pd_h, pd_v} <= '0;
      pd_valid <= 1'b0;
      sample_new <= 1'b0;
      cnt <= '0;
      cpu_dout <= '0;
      cpu_dout_valid <= 1'b0;
    end else begin
      state <= state_d;
      tick_q <= cnt_4ms;
      {sh_h, sh_v, pd_h, pd_v} <= {sh_h_d, sh_v_d, pd_h_d, pd_v_d};
      pd_valid <= pd_valid_d;
      sample_new <= new_d;
      cnt <= cnt_d;
      cpu_dout_valid <= cpu_rd;
      if (cpu_rd) cpu_dout <= {sample_new, 1'b0, (cpu_sel == SEL_V) ? sh_v : sh_h};
    end
`ifdef GUN_CROSSHAIR_EN
  gun_crosshair #(.H_OFFSET(H_OFFSET), .V_OFFSET(V_OFFSET)) u_xhair (
    .clock_12(clock_12), .reset_n(reset_n), .sh_h(sh_h), .sh_v(sh_v),
    .hcnt(hcnt), .vcnt(vcnt), .xhair(xhair)
  );
`else
  logic unused_xh;
  assign unused_xh = ^{hcnt, vcnt, H_OFFSET, V_OFFSET};
  assign xhair = 1'b0;
`endif
endmodule

// File: tb/tb_gun_port_responder.sv
// tb_gun_port_responder: directed stimulus against a cycle-indexed behavioural model of the responder
module tb_gun_port_responder;
  localparam int L = 16;
  logic clk = 1'b0;
  logic reset_n, cnt_4ms, cpu_rd, cpu_sel, cpu_dout_valid, sample_new, xhair;
  logic [5:0] gun_h, gun_v;
  logic [7:0] cpu_dout;
  logic [8:0] hcnt, vcnt;
  int checks = 0, failures = 0;
  logic chk_en = 1'b0;
  logic [7:0] e_dout;
  logic e_valid, e_new, e_x;
  logic [5:0] m_sh, m_sv;
  logic m_new, m_locked, m_prev;
  int k, m_deadline;
  logic [11:0] m_pq[$];

  gun_port_responder #(.LOCK_TIMEOUT(L), .H_OFFSET(48), .V_OFFSET(16)) dut (
    .clock_12(clk), .reset_n(reset_n), .gun_h(gun_h), .gun_v(gun_v), .cnt_4ms(cnt_4ms),
    .cpu_rd(cpu_rd), .cpu_sel(cpu_sel), .cpu_dout(cpu_dout), .cpu_dout_valid(cpu_dout_valid),
    .sample_new(sample_new), .hcnt(hcnt), .vcnt(vcnt), .xhair(xhair)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("dout_valid", {7'd0, cpu_dout_valid}, {7'd0, e_valid});
    chk("dout", cpu_dout, e_dout);
    chk("sample_new", {7'd0, sample_new}, {7'd0, e_new});
    chk("xhair", {7'd0, xhair}, {7'd0, e_x});
  end

  function automatic logic xh_model(input int h, input int v);
`ifdef GUN_CROSSHAIR_EN
    int x = 48 + 4 * int'(m_sh);
    int y = 16 + 4 * int'(m_sv);
    return (v == y && h - x <= 3 && x - h <= 3) || (h == x && v - y <= 3 && y - v <= 3);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [5:0] clamp(input logic [5:0] g);
    return (g == 6'd63) ? 6'd62 : g;
  endfunction

  task automatic promote();
    {m_sh, m_sv} = m_pq.pop_front();
    m_new = 1'b1;
  endtask

  task automatic step(input logic c, input logic rd, input logic sel);
    logic tk, prom;
    logic [11:0] smp;
    @(negedge clk); #1;
    cnt_4ms = c; cpu_rd = rd; cpu_sel = sel;
    e_x = xh_model(int'(hcnt), int'(vcnt));
    e_valid = rd;
    if (rd) e_dout = {m_new, 1'b0, sel ? m_sv : m_sh};
    tk = c && !m_prev;
    m_prev = c;
    smp = {clamp(gun_h), clamp(gun_v)};
    k++;
    if (!m_locked) begin
      prom = m_pq.size() != 0;
      if (prom) promote();
      if (rd && !sel) begin
        m_locked = 1'b1;
        m_deadline = k + L;
        m_new = prom;
        if (tk) begin m_pq.delete(); m_pq.push_back(smp); end
      end else if (tk) begin
        {m_sh, m_sv} = smp;
        m_new = 1'b1;
      end
    end else begin
      prom = m_pq.size() != 0 && !tk;
      if (tk) begin m_pq.delete(); m_pq.push_back(smp); end
      if (rd && !sel) m_deadline = k + L;
      else if ((rd && sel) || k == m_deadline) begin
        m_locked = 1'b0;
        if (prom) promote();
      end
    end
    e_new = m_new;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    reset_n = 1'b0; cnt_4ms = 1'b0; cpu_rd = 1'b0; cpu_sel = 1'b0;
    #1;
    chk("rst_dout", cpu_dout, 8'h00);
    chk("rst_valid", {7'd0, cpu_dout_valid}, 8'h00);
    chk("rst_new", {7'd0, sample_new}, 8'h00);
    chk("rst_xhair", {7'd0, xhair}, 8'h00);
    {m_sh, m_sv, m_new, m_locked, m_prev} = '0;
    m_pq.delete();
    {e_dout, e_valid, e_new, e_x} = '0;
    k = 0; m_deadline = 0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int hs[5] = '{48, 45, 51, 48, 52};
    int vs[5] = '{16, 16, 16, 19, 16};
    logic ex[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    reset_n = 1'b1; cnt_4ms = 0; cpu_rd = 0; cpu_sel = 0;
    gun_h = 0; gun_v = 0; hcnt = 0; vcnt = 0;
    do_reset();
    // crosshair around the origin sample (48,16)
    for (int i = 0; i < 5; i++) begin
      hcnt = 9'(hs[i]); vcnt = 9'(vs[i]);
      step(0, 0, 0); step(0, 0, 0);
`ifdef GUN_CROSSHAIR_EN
      chk("xh_lit", {7'd0, xhair}, {7'd0, ex[i]});
`else
      chk("xh_off", {7'd0, xhair}, {7'd0, ex[i] & 1'b0});
`endif
    end
    hcnt = 0; vcnt = 0;
    // basic sample and H/V read
    gun_h = 10; gun_v = 20;
    step(1, 0, 0); step(0, 0, 0); step(0, 1, 0); step(0, 1, 1);
    chk("t1_h", cpu_dout, 8'h8A);
    step(0, 0, 0);
    chk("t1_v", cpu_dout, 8'h14);
    chk("t1_new", {7'd0, sample_new}, 8'h00);
    // clamp 63 -> 62
    gun_h = 63;
    step(1, 0, 0); step(0, 0, 0); step(0, 1, 0); step(0, 1, 1);
    chk("t2_clamp", cpu_dout, 8'hBE);
    step(0, 0, 0);
    // tick while locked goes to pending, promoted on V-read release
    step(0, 1, 0);
    gun_h = 5; gun_v = 6;
    step(1, 0, 0); step(0, 0, 0); step(0, 1, 1); step(0, 1, 0);
    chk("t3_v_old", cpu_dout, 8'h14);
    step(0, 1, 1);
    chk("t3_h_new", cpu_dout, 8'h85);
    step(0, 0, 0);
    chk("t3_v", cpu_dout, 8'h06);
    // timeout release with pending posted at cycle 8
    gun_h = 7; gun_v = 9;
    step(0, 1, 0);
    for (int i = 1; i <= L; i++) step(i == 8, 0, 0);
    chk("t4_before", {7'd0, sample_new}, 8'h00);
    step(0, 0, 0);
    chk("t4_at_l", {7'd0, sample_new}, 8'h01);
    step(0, 1, 0); step(0, 1, 1);
    chk("t4_h", cpu_dout, 8'h87);
    step(0, 0, 0);
    chk("t4_v", cpu_dout, 8'h09);
    // tick and H read together
    gun_h = 11; gun_v = 12;
    step(1, 1, 0); step(0, 0, 0);
    chk("t5_pre", cpu_dout, 8'h07);
    chk("t5_new", {7'd0, sample_new}, 8'h00);
    step(0, 1, 1); step(0, 0, 0);
    chk("t5_v", cpu_dout, 8'h09);
    chk("t5_prom", {7'd0, sample_new}, 8'h01);
    // tick and V read together while locked
    step(0, 1, 0);
    gun_h = 13; gun_v = 14;
    step(1, 1, 1); step(0, 0, 0);
    chk("t5b_v", cpu_dout, 8'h0C);
    chk("t5b_wait", {7'd0, sample_new}, 8'h00);
    step(0, 0, 0);
    chk("t5b_prom", {7'd0, sample_new}, 8'h01);
    // reset while locked with pending
    step(0, 1, 0);
    gun_h = 30; gun_v = 31;
    step(1, 0, 0); step(0, 0, 0);
    do_reset();
    step(0, 1, 1); step(0, 0, 0);
    chk("t6_v", cpu_dout, 8'h00);
    step(0, 0, 0); step(0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
